div_lz_iter: RTL and testbench

- Multi-cycle 32-bit integer divider for the EXE stage (div.w/mod.w, signed and unsigned).
- Sits directly downstream of the leading-zero counter and consumes its count of the dividend magnitude.
- Uses that count to skip leading-zero iterations (early-out), then runs restoring radix-2 steps.
- Returns quotient and remainder together under a valid/ready handshake.

---
 rtl/div_pkg.sv | 7 +
 rtl/div_lz_iter_if.sv | 24 ++
 rtl/div_step.sv | 19 +
 rtl/div_lz_iter.sv | 118 +++++++++++
 tb/tb_div_lz_iter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared widths, FSM encoding and constants for the iterative divider.
package div_pkg;
  localparam int DIV_W = 32;
  localparam int LZ_W  = 6;
  localparam logic [DIV_W-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  typedef enum logic [2:0] {IDLE, PRESHIFT, ITER, FIX, DONE} div_state_e;
endpackage

// File: rtl/div_lz_iter_if.sv
// div_lz_iter_if: operand/result handshake bundle between the EXE stage and the divider.
interface div_lz_iter_if;
  import div_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic             div_signed;
  logic [DIV_W-1:0] x;
  logic [DIV_W-1:0] y;
  logic [LZ_W-1:0]  x_lz;
  logic             cancel;
  logic             out_valid;
  logic             out_ready;
  logic [DIV_W-1:0] q;
  logic [DIV_W-1:0] r;
  logic             busy;
  modport master (
    output in_valid, div_signed, x, y, x_lz, cancel, out_ready,
    input  in_ready, out_valid, q, r, busy
  );
  modport slave (
    input  in_valid, div_signed, x, y, x_lz, cancel, out_ready,
    output in_ready, out_valid, q, r, busy
  );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step on {rem, dividend_bit} against d.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem,
  input  logic             dividend_bit,
  input  logic [DIV_W-1:0] d,
  output logic [DIV_W-1:0] rem_next,
  output logic             q_bit
);
  logic [DIV_W:0] trial;
  logic [DIV_W:0] diff;
  always_comb begin
    trial    = {rem, dividend_bit};
    diff     = trial - {1'b0, d};
    q_bit    = trial >= {1'b0, d};
    rem_next = q_bit ? diff[DIV_W-1:0] : trial[DIV_W-1:0];
  end
endmodule

// File: rtl/div_lz_iter.sv
// div_lz_iter: multi-cycle signed/unsigned divider that skips leading-zero steps of |x|.
// Early-out on x_lz is enabled by DIV_EARLY_OUT_EN; otherwise every step is run.
module div_lz_iter
  import div_pkg::*;
(
  input  logic clk,
  input  logic reset,
  div_lz_iter_if.slave bus
);
  div_state_e       state;
  div_state_e       state_next;
  logic [DIV_W-1:0] xs;
  logic [DIV_W-1:0] d;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] qacc;
  logic [DIV_W-1:0] x_raw;
  logic [DIV_W-1:0] q_res;
  logic [DIV_W-1:0] r_res;
  logic [DIV_W-1:0] rem_step;
  logic [LZ_W-1:0]  lz;
  logic [LZ_W-1:0]  lz_in;
  logic [LZ_W-1:0]  n;
  logic             sign_q;
  logic             sign_r;
  logic             q_bit;
  logic             accept;
  logic             neg_x;
  logic             neg_y;

`ifdef DIV_EARLY_OUT_EN
  assign lz_in = bus.x_lz > LZ_W'(DIV_W) ? LZ_W'(DIV_W) : bus.x_lz;
`else
  assign lz_in = '0;
`endif

  assign accept        = bus.in_valid && state == IDLE && !bus.cancel;
  assign neg_x         = bus.div_signed && bus.x[DIV_W-1];
  assign neg_y         = bus.div_signed && bus.y[DIV_W-1];
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy      = state != IDLE;
  assign bus.q         = q_res;
  assign bus.r         = r_res;

  div_step u_step (
    .rem          (rem),
    .dividend_bit (xs[DIV_W-1]),
    .d            (d),
    .rem_next     (rem_step),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else       state <= state_next;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = accept ? PRESHIFT : IDLE;
      PRESHIFT: state_next = d == '0 ? DONE : lz == LZ_W'(DIV_W) ? FIX : ITER;
      ITER:     state_next = n == LZ_W'(1) ? FIX : ITER;
      FIX:      state_next = DONE;
      DONE:     state_next = bus.out_ready ? IDLE : DONE;
      default:  state_next = IDLE;
    endcase
    if (bus.cancel) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xs     <= '0;
      d      <= '0;
      rem    <= '0;
      qacc   <= '0;
      x_raw  <= '0;
      q_res  <= '0;
      r_res  <= '0;
      lz     <= '0;
      n      <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x_raw  <= bus.x;
          xs     <= neg_x ? -bus.x : bus.x;
          d      <= neg_y ? -bus.y : bus.y;
          sign_q <= neg_x ^ neg_y;
          sign_r <= neg_x;
          lz     <= lz_in;
        end
        PRESHIFT: begin
          // lz == DIV_W shifts everything out, leaving a zero quotient and remainder
          xs   <= xs << lz;
          n    <= LZ_W'(DIV_W) - lz;
          rem  <= '0;
          qacc <= '0;
          if (d == '0) begin
            q_res <= DIV_BY_ZERO_Q;
            r_res <= x_raw;
          end
        end
        ITER: begin
          rem  <= rem_step;
          xs   <= xs << 1;
          qacc <= {qacc[DIV_W-2:0], q_bit};
          n    <= n - LZ_W'(1);
        end
        FIX: begin
          q_res <= sign_q ? -qacc : qacc;
          r_res <= sign_r ? -rem : rem;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_lz_iter.sv
// tb_div_lz_iter: directed vectors for div_lz_iter with hand-computed results and latencies.
module tb_div_lz_iter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  div_lz_iter_if bus ();

  div_lz_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // el is the early-out latency; without early-out any nonzero divisor takes 35
  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] lz, input logic [31:0] eq, input logic [31:0] er,
                        input int el, input int hold);
    int cnt;
    int lat;
    lat = el;
`ifndef DIV_EARLY_OUT_EN
    if (b != 0) lat = 35;
`endif
    bus.div_signed = s;
    bus.x = a;
    bus.y = b;
    bus.x_lz = lz;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cnt = 1;
    while (!bus.out_valid && cnt < 60) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_lat"}, cnt, lat);
    check({tag, "_q"}, bus.q, eq);
    check({tag, "_r"}, bus.r, er);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
      check({tag, "_hold_q"}, bus.q, eq);
      check({tag, "_hold_r"}, bus.r, er);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.div_signed = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.x_lz = '0;
    bus.cancel = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_q", bus.q, 32'd0);
    check("rst_r", bus.r, 32'd0);

    run_op("s100d7",   1'b1, 32'd100,        32'd7,          6'd25, 32'd14,         32'd2,          10, 0);
    run_op("sm100d7",  1'b1, 32'hFFFF_FF9C,  32'd7,          6'd25, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  10, 0);
    run_op("umaxd1",   1'b0, 32'hFFFF_FFFF,  32'd1,          6'd0,  32'hFFFF_FFFF,  32'd0,          35, 0);
    run_op("u5d0",     1'b0, 32'd5,          32'd0,          6'd29, 32'hFFFF_FFFF,  32'd5,          2,  0);
    run_op("sm7d0",    1'b1, 32'hFFFF_FFF9,  32'd0,          6'd29, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  2,  0);
    run_op("sovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  6'd0,  32'h8000_0000,  32'd0,          35, 0);
    run_op("x0",       1'b1, 32'd0,          32'd5,          6'd32, 32'd0,          32'd0,          3,  0);
    run_op("x0clamp",  1'b0, 32'd0,          32'd9,          6'd40, 32'd0,          32'd0,          3,  0);
    run_op("understa", 1'b0, 32'd100,        32'd7,          6'd0,  32'd14,         32'd2,          35, 0);
    run_op("u20d6hld", 1'b0, 32'd20,         32'd6,          6'd27, 32'd3,          32'd2,          8,  5);

    // cancel while iterating
    bus.div_signed = 1'b0;
    bus.x = 32'd100;
    bus.y = 32'd7;
    bus.x_lz = 6'd0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("cancel_busy_before", 32'(bus.busy), 32'd1);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    check("cancel_out_valid", 32'(bus.out_valid), 32'd0);
    check("cancel_in_ready", 32'(bus.in_ready), 32'd1);
    check("cancel_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("cancel_stays_idle", 32'(bus.out_valid), 32'd0);

    // cancel together with in_valid: not accepted
    bus.in_valid = 1'b1;
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.cancel = 1'b0;
    check("cancel_acc_busy", 32'(bus.busy), 32'd0);
    check("cancel_acc_ready", 32'(bus.in_ready), 32'd1);

    run_op("u9d3", 1'b0, 32'd9, 32'd3, 6'd28, 32'd3, 32'd0, 7, 0);

    // reset in the middle of an operation
    bus.div_signed = 1'b1;
    bus.x = 32'd100;
    bus.y = 32'd7;
    bus.x_lz = 6'd25;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_q", bus.q, 32'd0);
    check("midrst_r", bus.r, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
